// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, forwarding select and bubble tracking
// for the 5-stage pipeline. A scoreboard follows in-flight register writes
// through the tracked stages EX..(EX+DEPTH-1). For the instruction in ID it
// drives stall, flush and forwarding selects. It also keeps saturating
// stall, flush and retire counters for the debug display.
//
// Ports:
//   CCLK, reset             clock, synchronous active-high reset
//   step                    pipeline advances one stage while high
//   id_*                    description of the instruction currently in ID
//   stall, flush_if         combinational pipeline control
//   fwd_a_sel, fwd_b_sel    0 = regfile, k = result of tracked stage k-1
//   stage_valid             valid bit per tracked stage (bit0 = EX)
//   stall_cnt, flush_cnt,   saturating performance counters
//   retire_cnt
module pipe_hazard_ctrl #(
  parameter int unsigned RA_W   = 5,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             CCLK,
  input  logic             reset,
  input  logic             step,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic             id_rs_used,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_rt_used,
  input  logic             id_wr,
  input  logic [RA_W-1:0]  id_wdst,
  input  logic             id_load,
  input  logic             id_redirect,
  output logic             stall,
  output logic             flush_if,
  output logic [2:0]       fwd_a_sel,
  output logic [2:0]       fwd_b_sel,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  // Scoreboard, index 0 = EX (youngest).
  logic [DEPTH-1:0] sb_v;
  logic [DEPTH-1:0] sb_wr;
  logic [DEPTH-1:0] sb_ld;
  logic [RA_W-1:0]  sb_dst [DEPTH];

  logic [DEPTH-1:0] hit_a;
  logic [DEPTH-1:0] hit_b;
  logic             raw_any;
  logic             load_use;

  // Per-entry RAW match against each ID source; r0 never hazards.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      hit_a[k] = sb_v[k] & sb_wr[k] & (sb_dst[k] == id_rs) & (id_rs != '0)
                 & id_rs_used & id_valid;
      hit_b[k] = sb_v[k] & sb_wr[k] & (sb_dst[k] == id_rt) & (id_rt != '0)
                 & id_rt_used & id_valid;
    end
  end

  assign raw_any  = (|hit_a) | (|hit_b);
  assign load_use = (hit_a[0] | hit_b[0]) & sb_ld[0];

  // With forwarding, only a load still in EX cannot supply its result in time.
  assign stall    = (FWD_EN != 0) ? load_use : raw_any;
  assign flush_if = id_redirect & id_valid & ~stall;

  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if (FWD_EN != 0) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (hit_a[k]) fwd_a_sel = 3'(k + 1);
        if (hit_b[k]) fwd_b_sel = 3'(k + 1);
      end
    end
  end

  assign stage_valid = sb_v;

  // Scoreboard shift and saturating counters, advancing only on step.
  always_ff @(posedge CCLK) begin
    if (reset) begin
      sb_v       <= '0;
      sb_wr      <= '0;
      sb_ld      <= '0;
      for (int k = 0; k < int'(DEPTH); k++) sb_dst[k] <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else if (step) begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) sb_dst[k] <= sb_dst[k-1];
      sb_v[DEPTH-1:1]  <= sb_v[DEPTH-2:0];
      sb_wr[DEPTH-1:1] <= sb_wr[DEPTH-2:0];
      sb_ld[DEPTH-1:1] <= sb_ld[DEPTH-2:0];
      if (stall) begin
        sb_v[0]   <= 1'b0;
        sb_wr[0]  <= 1'b0;
        sb_ld[0]  <= 1'b0;
        sb_dst[0] <= '0;
      end else begin
        sb_v[0]   <= id_valid;
        sb_wr[0]  <= id_wr & id_valid;
        sb_ld[0]  <= id_load & id_valid;
        sb_dst[0] <= id_wdst;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (sb_v[DEPTH-1] && (retire_cnt != '1))
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances sharing one ID stream, one
// stall-only (DEPTH=2, 4-bit counters) and one forwarding (DEPTH=3), each
// compared against an instruction-level pipeline model every cycle.
module tb_pipe_hazard_ctrl;

  logic       CCLK;
  logic       reset, step, id_valid, id_rs_used, id_rt_used;
  logic       id_wr, id_load, id_redirect;
  logic [4:0] id_rs, id_rt, id_wdst;

  logic       st0, fl0, st1, fl1;
  logic [2:0] fa0, fb0, fa1, fb1;
  logic [1:0] sv0;
  logic [2:0] sv1;
  logic [3:0] sc0, fc0, rc0;
  logic [15:0] sc1, fc1, rc1;

  pipe_hazard_ctrl #(.RA_W(5), .DEPTH(2), .FWD_EN(0), .CNT_W(4)) u_dut0 (
    .CCLK(CCLK), .reset(reset), .step(step), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr(id_wr), .id_wdst(id_wdst), .id_load(id_load), .id_redirect(id_redirect),
    .stall(st0), .flush_if(fl0), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
    .stage_valid(sv0), .stall_cnt(sc0), .flush_cnt(fc0), .retire_cnt(rc0));

  pipe_hazard_ctrl #(.RA_W(5), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_dut1 (
    .CCLK(CCLK), .reset(reset), .step(step), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr(id_wr), .id_wdst(id_wdst), .id_load(id_load), .id_redirect(id_redirect),
    .stall(st1), .flush_if(fl1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
    .stage_valid(sv1), .stall_cnt(sc1), .flush_cnt(fc1), .retire_cnt(rc1));

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  // Reference model: each instance's in-flight instructions, oldest last.
  typedef struct packed {
    bit       v;
    bit       wr;
    bit [4:0] dst;
    bit       ld;
  } ent_t;

  ent_t m [2][4];
  int   dep  [2] = '{2, 3};
  bit   fwd  [2] = '{1'b0, 1'b1};
  int   cmax [2] = '{15, 65535};
  int   msc [2], mfc [2], mrc [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
  endtask

  function automatic bit hit(input ent_t e, input bit [4:0] s, input bit used);
    return e.v && e.wr && (e.dst == s) && (s != 5'd0) && used && id_valid;
  endfunction

  function automatic void mdl_eval(input int u, output bit st, output bit fl,
                                   output bit [2:0] fa, output bit [2:0] fb);
    bit any_hit, ha, hb, use0;
    any_hit = 0; use0 = 0; fa = 0; fb = 0;
    for (int k = 0; k < dep[u]; k++) begin
      ha = hit(m[u][k], id_rs, id_rs_used);
      hb = hit(m[u][k], id_rt, id_rt_used);
      if (ha && fa == 0) fa = 3'(k + 1);
      if (hb && fb == 0) fb = 3'(k + 1);
      if (ha || hb) any_hit = 1;
      if (k == 0 && (ha || hb) && m[u][0].ld) use0 = 1;
    end
    if (fwd[u]) st = use0;
    else begin
      st = any_hit; fa = 0; fb = 0;
    end
    fl = id_redirect && id_valid && !st;
  endfunction

  function automatic int sat_inc(input int c, input int mx);
    return (c < mx) ? c + 1 : c;
  endfunction

  task automatic drive(input bit rst, input bit stp, input bit vld,
                       input bit [4:0] rs, input bit ru, input bit [4:0] rt, input bit tu,
                       input bit wr, input bit [4:0] wd, input bit ld, input bit rd);
    reset = rst; step = stp; id_valid = vld;
    id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
    id_wr = wr; id_wdst = wd; id_load = ld; id_redirect = rd;
    #1;
  endtask

  // Compare every output of both instances with the model, then clock once.
  task automatic tick();
    bit       st [2], fl [2];
    bit [2:0] fa [2], fb [2];
    logic [31:0] svx;
    for (int u = 0; u < 2; u++) begin
      mdl_eval(u, st[u], fl[u], fa[u], fb[u]);
      svx = 0;
      for (int k = 0; k < dep[u]; k++) svx[k] = m[u][k].v;
      check_eq($sformatf("u%0d stall", u),  32'(u ? st1 : st0), 32'(st[u]));
      check_eq($sformatf("u%0d flush", u),  32'(u ? fl1 : fl0), 32'(fl[u]));
      check_eq($sformatf("u%0d fwd_a", u),  32'(u ? fa1 : fa0), 32'(fa[u]));
      check_eq($sformatf("u%0d fwd_b", u),  32'(u ? fb1 : fb0), 32'(fb[u]));
      check_eq($sformatf("u%0d valid", u),  u ? 32'(sv1) : 32'(sv0), svx);
      check_eq($sformatf("u%0d stall_cnt", u),  u ? 32'(sc1) : 32'(sc0), 32'(msc[u]));
      check_eq($sformatf("u%0d flush_cnt", u),  u ? 32'(fc1) : 32'(fc0), 32'(mfc[u]));
      check_eq($sformatf("u%0d retire_cnt", u), u ? 32'(rc1) : 32'(rc0), 32'(mrc[u]));
    end
    @(posedge CCLK);
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        for (int k = 0; k < 4; k++) m[u][k] = '0;
        msc[u] = 0; mfc[u] = 0; mrc[u] = 0;
      end else if (step) begin
        if (st[u]) msc[u] = sat_inc(msc[u], cmax[u]);
        if (fl[u]) mfc[u] = sat_inc(mfc[u], cmax[u]);
        if (m[u][dep[u]-1].v) mrc[u] = sat_inc(mrc[u], cmax[u]);
        for (int k = dep[u] - 1; k > 0; k--) m[u][k] = m[u][k-1];
        if (st[u]) m[u][0] = '0;
        else m[u][0] = '{v: id_valid, wr: id_wr && id_valid, dst: id_wdst,
                         ld: id_load && id_valid};
      end
    end
    @(negedge CCLK);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 4; k++) m[u][k] = '0;
      msc[u] = 0; mfc[u] = 0; mrc[u] = 0;
    end
    reset = 1; step = 0; id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0;
    id_rt_used = 0; id_wr = 0; id_wdst = 0; id_load = 0; id_redirect = 0;
    @(posedge CCLK); @(negedge CCLK);

    // Idle cycle right after reset: everything must read zero.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // add r3 followed by readers of r3.
    drive(0, 1, 1, 0, 0, 0, 0, 1, 3, 0, 0); tick();
    drive(0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    check_eq("raw stall nofwd", 32'(st0), 1);
    check_eq("raw nostall fwd", 32'(st1), 0);
    check_eq("fwd from EX", 32'(fa1), 1);
    tick();
    check_eq("valid add in MEM", 32'(sv0), 2);
    check_eq("fwd from MEM", 32'(fa1), 2);
    check_eq("raw stall 2nd", 32'(st0), 1);
    tick();
    check_eq("stall released", 32'(st0), 0);
    check_eq("stall_cnt two", 32'(sc0), 2);
    check_eq("bubbles drained", 32'(sv0), 0);
    check_eq("fwd from WB", 32'(fa1), 3);
    tick();

    // lw r5 then a reader of rt=5.
    drive(0, 1, 1, 0, 0, 0, 0, 1, 5, 1, 0); tick();
    drive(0, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    check_eq("load-use stall", 32'(st1), 1);
    tick();
    check_eq("load-use one step", 32'(st1), 0);
    check_eq("load fwd MEM", 32'(fb1), 2);
    tick();

    // Writes to r0 never create hazards.
    drive(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0); tick();
    drive(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    check_eq("r0 nostall0", 32'(st0), 0);
    check_eq("r0 nostall1", 32'(st1), 0);
    check_eq("r0 fwd_a", 32'(fa1), 0);
    check_eq("r0 fwd_b", 32'(fb1), 0);
    tick();

    // Redirect without and with a hazard.
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("redirect flush", 32'(fl0), 1);
    tick();
    drive(0, 1, 1, 0, 0, 0, 0, 1, 6, 1, 0); tick();
    drive(0, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1);
    check_eq("redirect blocked", 32'(fl1), 0);
    tick();
    check_eq("redirect after stall", 32'(fl1), 1);
    check_eq("redirect still blocked", 32'(fl0), 0);
    tick();
    tick();

    // Drive the 4-bit stall counter into saturation.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 1, 3, 0, 0); tick();
      drive(0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0); tick(); tick();
    end
    check_eq("stall_cnt saturated", 32'(sc0), 15);

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0));
      tick();
    end

    // Reset in the middle of a stall.
    drive(0, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0); tick();
    drive(1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    check_eq("stall before reset", 32'(st0), 1);
    tick();
    drive(0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    check_eq("stall after reset", 32'(st0), 0);
    check_eq("stall_cnt after reset", 32'(sc0), 0);
    check_eq("valid after reset", 32'(sv1), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
